fp_run_ctrl: RTL
================

FP_RUN_CTRL -- requirements
Module: fp_run_ctrl

Interface
REQ-001 SHALL have parameter N_MAX, default 8, meaning the maximum number of inferences per batch.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the external image-memory address width.
REQ-003 SHALL have parameter TMO_W, default 16, meaning the per-run timeout counter width.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port cmd_start, input, 1 bit: one-cycle batch launch request.
REQ-007 SHALL have port cmd_abort, input, 1 bit: one-cycle abort request.
REQ-008 SHALL have port cfg_batch, input, 4 bits: number of runs, valid range 1..N_MAX.
REQ-009 SHALL have port cfg_stride, input, ADDR_W bits: image base increment per run.
REQ-010 SHALL have port cfg_timeout, input, TMO_W bits: cycle limit per run; 0 disables the timeout.
REQ-011 SHALL have port fp_ap_start, output, 1 bit: forward_pass ap_start.
REQ-012 SHALL have ports fp_ap_ready and fp_ap_done, inputs, 1 bit each: forward_pass handshake.
REQ-013 SHALL have port fp_ap_return, input, 4 bits: forward_pass class result.
REQ-014 SHALL have port fp_rst, output, 1 bit: active-high reset to forward_pass.
REQ-015 SHALL have port fp_addr, input, ADDR_W bits: image_r_Addr_A low bits from forward_pass.
REQ-016 SHALL have port mem_addr, output, ADDR_W bits: translated external-memory address.
REQ-017 SHALL have outputs busy (1 bit), done_irq (1 bit), err_cfg (1 bit), err_tmo (1 bit), run_idx (4 bits) and results (4*N_MAX bits).

Function
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT, FLUSH and FIN.
REQ-019 In IDLE, cmd_start with cfg_batch in 1..N_MAX SHALL latch cfg_*, clear results, run_idx and base, clear err_*, and go to LAUNCH on the next cycle.
REQ-020 cmd_start in IDLE with cfg_batch of 0 or greater than N_MAX SHALL set err_cfg and remain in IDLE.
REQ-021 cmd_start outside IDLE SHALL be ignored; latched configuration SHALL NOT change mid-batch.
REQ-022 fp_ap_start SHALL be 1 exactly while in LAUNCH (registered output); LAUNCH SHALL exit to WAIT on the cycle fp_ap_ready=1.
REQ-023 fp_ap_done=1 in LAUNCH or WAIT SHALL complete the run; this includes ready and done asserted in the same cycle.
REQ-024 On run completion, results[4*run_idx +: 4] SHALL capture fp_ap_return, run_idx SHALL increment, and base SHALL increase by the latched stride, wrapping mod 2^ADDR_W.
REQ-025 After completion, if run_idx+1 equals the latched batch, the FSM SHALL go to FIN; otherwise it SHALL return to LAUNCH.
REQ-026 FIN SHALL last exactly one cycle, pulse done_irq=1 for that cycle, then go to IDLE.
REQ-027 mem_addr SHALL equal (fp_addr + base) mod 2^ADDR_W, combinationally, with 0 added latency.
REQ-028 The timeout counter SHALL clear at entry to each LAUNCH and increment every cycle in LAUNCH and WAIT.
REQ-029 If cfg_timeout is nonzero and the counter reaches cfg_timeout without a completion, the block SHALL set err_tmo and go to FLUSH.
REQ-030 cmd_abort in LAUNCH or WAIT SHALL go to FLUSH and take priority over a same-cycle fp_ap_done or timeout; cmd_abort SHALL be a no-op in other states.
REQ-031 FLUSH SHALL hold fp_rst=1 for exactly 2 cycles, then go to IDLE without done_irq; results already captured SHALL be retained.
REQ-032 busy SHALL be 1 in every state except IDLE.

Reset
REQ-033 While ap_rst_n=0, the block SHALL be in IDLE with all outputs 0 except mem_addr=fp_addr and fp_rst=1.
REQ-034 Reset asserted mid-batch SHALL abandon the batch immediately; no done_irq SHALL follow deassertion.

Structure
REQ-035 Package fp_ctrl_pkg SHALL hold the FSM state enum and the N_MAX, ADDR_W and TMO_W defaults.
REQ-036 The timeout counter SHALL be a sub-module fp_tmo_cnt with ports clear, enable, limit and expired.

Verification
REQ-037 batch=3, stride=0x310, fp_ap_return 5,2,9, done 10 cycles after ready -> results[11:0]=0x925, done_irq once, run_idx=3.
REQ-038 ready and done in the same cycle as the first LAUNCH cycle -> run counted once and fp_ap_start low on the next cycle.
REQ-039 timeout=20, done never asserted -> err_tmo at cycle 20 of the run, fp_rst high for 2 cycles, then IDLE.
REQ-040 cmd_abort coincident with fp_ap_done on run 2 -> FLUSH; results for run 2 not written; no done_irq.
REQ-041 stride=0x800, batch=3, fp_addr=0x900 during run 3 -> mem_addr=0x900 (wrap).
REQ-042 cfg_batch=0 or 9 -> err_cfg=1 and busy stays 0; ap_rst_n pulsed low in WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// Shared types and default sizing for the forward_pass run controller.
package fp_ctrl_pkg;

  localparam int unsigned NMaxDefault  = 8;
  localparam int unsigned AddrWDefault = 12;
  localparam int unsigned TmoWDefault  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StFlush,
    StFin
  } state_e;

endpackage

// File: rtl/fp_tmo_cnt.sv
// Per-run cycle counter; expired flags the cycle in which the count reaches limit.
module fp_tmo_cnt #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  // cnt_q counts completed cycles, so limit-1 marks the limit-th cycle of the run.
  assign expired = enable && (limit != '0) && (cnt_q == limit - TMO_W'(1));

endmodule

// File: rtl/fp_run_ctrl.sv
// Sequences a batch of forward_pass inferences, collecting class results and
// relocating the image window for each run.
module fp_run_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int unsigned N_MAX  = NMaxDefault,
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned TMO_W  = TmoWDefault
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic [3:0]         cfg_batch,
  input  logic [ADDR_W-1:0]  cfg_stride,
  input  logic [TMO_W-1:0]   cfg_timeout,
  output logic               fp_ap_start,
  input  logic               fp_ap_ready,
  input  logic               fp_ap_done,
  input  logic [3:0]         fp_ap_return,
  output logic               fp_rst,
  input  logic [ADDR_W-1:0]  fp_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               busy,
  output logic               done_irq,
  output logic               err_cfg,
  output logic               err_tmo,
  output logic [3:0]         run_idx,
  output logic [4*N_MAX-1:0] results
);

  state_e             state_q, state_d;
  logic [3:0]         batch_q, batch_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [TMO_W-1:0]   timeout_q, timeout_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [3:0]         run_idx_q, run_idx_d;
  logic [4*N_MAX-1:0] results_q, results_d;
  logic               err_cfg_q, err_cfg_d;
  logic               err_tmo_q, err_tmo_d;
  logic               flush_cnt_q, flush_cnt_d;
  logic               fp_rst_q;

  logic cfg_ok;
  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expired;

  assign cfg_ok     = (cfg_batch != 4'd0) && ({1'b0, cfg_batch} <= 5'(N_MAX));
  assign tmo_enable = (state_q == StLaunch) || (state_q == StWait);

  fp_tmo_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo_cnt (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .limit   (timeout_q),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    batch_d     = batch_q;
    stride_d    = stride_q;
    timeout_d   = timeout_q;
    base_d      = base_q;
    run_idx_d   = run_idx_q;
    results_d   = results_q;
    err_cfg_d   = err_cfg_q;
    err_tmo_d   = err_tmo_q;
    flush_cnt_d = flush_cnt_q;
    tmo_clear   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          if (cfg_ok) begin
            batch_d   = cfg_batch;
            stride_d  = cfg_stride;
            timeout_d = cfg_timeout;
            base_d    = '0;
            run_idx_d = '0;
            results_d = '0;
            err_cfg_d = 1'b0;
            err_tmo_d = 1'b0;
            tmo_clear = 1'b1;
            state_d   = StLaunch;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      StLaunch, StWait: begin
        // Abort beats completion, completion beats timeout.
        if (cmd_abort) begin
          flush_cnt_d = 1'b0;
          state_d     = StFlush;
        end else if (fp_ap_done) begin
          for (int unsigned i = 0; i < N_MAX; i++) begin
            if (run_idx_q == 4'(i)) begin
              results_d[4*i +: 4] = fp_ap_return;
            end
          end
          run_idx_d = run_idx_q + 4'd1;
          base_d    = base_q + stride_q;
          if (run_idx_q + 4'd1 == batch_q) begin
            state_d = StFin;
          end else begin
            tmo_clear = 1'b1;
            state_d   = StLaunch;
          end
        end else if (tmo_expired) begin
          err_tmo_d   = 1'b1;
          flush_cnt_d = 1'b0;
          state_d     = StFlush;
        end else if ((state_q == StLaunch) && fp_ap_ready) begin
          state_d = StWait;
        end
      end
      StFlush: begin
        if (flush_cnt_q) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      batch_q     <= '0;
      stride_q    <= '0;
      timeout_q   <= '0;
      base_q      <= '0;
      run_idx_q   <= '0;
      results_q   <= '0;
      err_cfg_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      flush_cnt_q <= 1'b0;
      fp_rst_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      batch_q     <= batch_d;
      stride_q    <= stride_d;
      timeout_q   <= timeout_d;
      base_q      <= base_d;
      run_idx_q   <= run_idx_d;
      results_q   <= results_d;
      err_cfg_q   <= err_cfg_d;
      err_tmo_q   <= err_tmo_d;
      flush_cnt_q <= flush_cnt_d;
      fp_rst_q    <= (state_d == StFlush);
    end
  end

  assign fp_ap_start = (state_q == StLaunch);
  assign fp_rst      = fp_rst_q;
  assign mem_addr    = fp_addr + base_q;
  assign busy        = (state_q != StIdle);
  assign done_irq    = (state_q == StFin);
  assign err_cfg     = err_cfg_q;
  assign err_tmo     = err_tmo_q;
  assign run_idx     = run_idx_q;
  assign results     = results_q;

endmodule
